rede_taylor_core: RTL and testbench



---
 rtl/rede_taylor_pkg.sv | 32 +++
 rtl/rede_taylor_core_mul.sv | 21 ++
 rtl/rede_taylor_core.sv | 141 ++++++++++++++
 tb/tb_rede_taylor_core.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rede_taylor_pkg.sv
// Shared constants for the rede Taylor neuron core: fixed-point format,
// tanh polynomial coefficients, weight table, bias and FSM state encoding.
package rede_taylor_pkg;

  localparam int unsigned FRAC_DEF = 10;
  localparam int unsigned N_IN_DEF = 4;
  localparam int unsigned DW       = 28;
  localparam int unsigned IW       = 19;
  localparam int unsigned ST_W     = 3;

  localparam logic signed [DW-1:0] ONE  = 28'sd1024;
  localparam logic signed [DW-1:0] C3   = -28'sd341;
  localparam logic signed [DW-1:0] C5   = 28'sd137;
  localparam logic signed [DW-1:0] BIAS = 28'sd0;

  localparam logic signed [DW-1:0] W_TAB [4] = '{28'sd1024, 28'sd512, -28'sd512, 28'sd256};

  localparam logic [ST_W-1:0] S_IDLE = 3'd0;
  localparam logic [ST_W-1:0] S_LOAD = 3'd1;
  localparam logic [ST_W-1:0] S_BIAS = 3'd2;
  localparam logic [ST_W-1:0] S_SQ   = 3'd3;
  localparam logic [ST_W-1:0] S_P1   = 3'd4;
  localparam logic [ST_W-1:0] S_P2   = 3'd5;
  localparam logic [ST_W-1:0] S_Y    = 3'd6;
  localparam logic [ST_W-1:0] S_OUT  = 3'd7;

  // Weight lookup; the table repeats if more samples than weights are used.
  function automatic logic signed [DW-1:0] weight_at(input logic [1:0] idx);
    return W_TAB[idx];
  endfunction

endpackage

// File: rtl/rede_taylor_core_mul.sv
// rt_fxp_mul: combinational signed fixed-point multiply, (a*b) >>> FRAC,
// truncated (wrapped) to DW bits. Shared by the MAC and polynomial steps.
import rede_taylor_pkg::*;

module rt_fxp_mul #(
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] prod_c
);

  logic signed [2*DW-1:0] full;

  // Full-precision product, floor shift, wrap to DW bits.
  always_comb begin
    full   = a * b;
    prod_c = DW'(full >>> FRAC);
  end

endmodule

// File: rtl/rede_taylor_core.sv
// rede_taylor_core: single neuron, weighted sum of N_IN samples plus bias,
// then tanh via truncated Taylor polynomial u*(1 + u2*(C3 + C5*u2)).
// Optional macro REDE_TAYLOR_CLAMP_EN saturates u to [-ONE, +ONE].
import rede_taylor_pkg::*;

module rede_taylor_core #(
  parameter int unsigned N_IN = N_IN_DEF,
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [IW-1:0] io_in,
  output logic signed [DW-1:0] io_out,
  output logic [3:0]           req_in,
  output logic [3:0]           out_en
);

  localparam int unsigned K_W = ($clog2(N_IN) > 2) ? $clog2(N_IN) : 2;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_IN - 1);

  logic [ST_W-1:0]      state_q, state_d;
  logic [K_W-1:0]       k_q, k_d;
  logic signed [DW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] u_q, u_d;
  logic signed [DW-1:0] u2_q, u2_d;
  logic signed [DW-1:0] p_q, p_d;
  logic signed [DW-1:0] io_out_q, io_out_d;
  logic [3:0]           req_in_q, req_in_d;
  logic [3:0]           out_en_q, out_en_d;

  logic signed [DW-1:0] mul_a, mul_b, mul_p;
  logic signed [DW-1:0] sum_c;

  rt_fxp_mul #(.FRAC(FRAC)) u_mul (
    .a      (mul_a),
    .b      (mul_b),
    .prod_c (mul_p)
  );

  // Next-state, datapath operand selection and registered output decode.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    u_d      = u_q;
    u2_d     = u2_q;
    p_d      = p_q;
    io_out_d = io_out_q;
    mul_a    = '0;
    mul_b    = '0;
    sum_c    = acc_q + BIAS;

    case (state_q)
      S_IDLE: begin
        acc_d   = '0;
        k_d     = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        mul_a = {{(DW-IW){io_in[IW-1]}}, io_in};
        mul_b = weight_at(k_q[1:0]);
        acc_d = acc_q + mul_p;
        k_d   = k_q + K_W'(1);
        if (k_q == K_LAST) state_d = S_BIAS;
      end
      S_BIAS: begin
`ifdef REDE_TAYLOR_CLAMP_EN
        if (sum_c > ONE)       u_d = ONE;
        else if (sum_c < -ONE) u_d = -ONE;
        else                   u_d = sum_c;
`else
        u_d = sum_c;
`endif
        state_d = S_SQ;
      end
      S_SQ: begin
        mul_a   = u_q;
        mul_b   = u_q;
        u2_d    = mul_p;
        state_d = S_P1;
      end
      S_P1: begin
        mul_a   = C5;
        mul_b   = u2_q;
        p_d     = mul_p + C3;
        state_d = S_P2;
      end
      S_P2: begin
        mul_a   = p_q;
        mul_b   = u2_q;
        p_d     = mul_p + ONE;
        state_d = S_Y;
      end
      S_Y: begin
        mul_a    = p_q;
        mul_b    = u_q;
        io_out_d = mul_p;
        state_d  = S_OUT;
      end
      S_OUT: begin
        acc_d   = '0;
        k_d     = '0;
        state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    req_in_d = (state_d == S_LOAD) ? 4'b0001 : 4'b0000;
    out_en_d = (state_d == S_OUT)  ? 4'b0001 : 4'b0000;
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      acc_q    <= '0;
      u_q      <= '0;
      u2_q     <= '0;
      p_q      <= '0;
      io_out_q <= '0;
      req_in_q <= '0;
      out_en_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      u_q      <= u_d;
      u2_q     <= u2_d;
      p_q      <= p_d;
      io_out_q <= io_out_d;
      req_in_q <= req_in_d;
      out_en_q <= out_en_d;
    end
  end

  assign io_out = io_out_q;
  assign req_in = req_in_q;
  assign out_en = out_en_q;

endmodule

// File: tb/tb_rede_taylor_core.sv
// Bench for rede_taylor_core: directed and random sample sets, each result
// predicted by an arithmetic model of the neuron and tanh polynomial.
module tb_rede_taylor_core;

  localparam int NI  = 4;
  localparam int PER = NI + 6;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [18:0] io_in = '0;
  logic signed [27:0] io_out;
  logic [3:0]         req_in;
  logic [3:0]         out_en;

  rede_taylor_core dut (
    .clk    (clk),
    .rst    (rst),
    .io_in  (io_in),
    .io_out (io_out),
    .req_in (req_in),
    .out_en (out_en)
  );

  always #5 clk = ~clk;

  int                 n_chk  = 0;
  int                 n_fail = 0;
  int                 cyc    = 0;
  longint             shown  = 0;
  longint             samp [NI];
  logic signed [18:0] stim_q [$];

  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic longint wrap28(input longint x);
    logic [27:0] t;
    t = x[27:0];
    return longint'($signed(t));
  endfunction

  // Neuron reference: MAC with weights, bias, optional clamp, tanh polynomial.
  function automatic longint ref_neuron(input longint s [NI]);
    longint w [4];
    longint acc, u, u2, p;
    w[0] = 1024; w[1] = 512; w[2] = -512; w[3] = 256;
    acc = 0;
    for (int i = 0; i < NI; i++) acc = wrap28(acc + ((s[i] * w[i % 4]) >>> 10));
    u = wrap28(acc + 0);
`ifdef REDE_TAYLOR_CLAMP_EN
    if (u > 1024) u = 1024;
    else if (u < -1024) u = -1024;
`endif
    u2 = wrap28((u * u) >>> 10);
    p  = wrap28(((137 * u2) >>> 10) - 341);
    p  = wrap28(((p * u2) >>> 10) + 1024);
    return wrap28((p * u) >>> 10);
  endfunction

  task automatic push4(input int a, input int b, input int c, input int d);
    stim_q.push_back(19'(a));
    stim_q.push_back(19'(b));
    stim_q.push_back(19'(c));
    stim_q.push_back(19'(d));
  endtask

  // One cycle: check outputs against the schedule, drive io_in, advance.
  task automatic step();
    int                 p;
    bit                 is_load;
    bit                 is_out;
    logic signed [18:0] v;
    p = 0; is_load = 1'b0; is_out = 1'b0;
    if (cyc > 0) begin
      p       = (cyc - 1) % PER;
      is_load = (p < NI);
      is_out  = (p == PER - 1);
    end
    if (is_out) shown = ref_neuron(samp);
    chk("req_in", 28'(req_in), is_load ? 28'd1 : 28'd0);
    chk("out_en", 28'(out_en), is_out ? 28'd1 : 28'd0);
    chk("io_out", io_out, 28'(shown));
    if (is_load) begin
      if (stim_q.size() > 0) v = stim_q.pop_front();
      else v = 19'($urandom);
      samp[p] = longint'(v);
    end else begin
      v = 19'($urandom);
    end
    io_in = v;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int n_per;
    repeat (3) @(negedge clk);
    chk("rst_io_out", io_out, 28'd0);
    chk("rst_req_in", 28'(req_in), 28'd0);
    chk("rst_out_en", 28'(out_en), 28'd0);

    // Reset pulse during the load phase aborts the evaluation.
    push4(int'($urandom_range(0, 4095)) - 2048, 700, -300, 900);
    rst = 1'b0;
    cyc = 0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("abort_io_out", io_out, 28'd0);
    chk("abort_req_in", 28'(req_in), 28'd0);
    chk("abort_out_en", 28'(out_en), 28'd0);
    stim_q.delete();
    shown = 0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_hold_req_in", 28'(req_in), 28'd0);
    rst = 1'b0;
    cyc = 0;

    // Directed sets, a free-running constant set, then random sets.
    push4(0, 0, 0, 0);
    push4(512, 0, 0, 0);
    push4(-512, 0, 0, 0);
    push4(4096, 0, 0, 0);
    repeat (3) push4(300, -200, 100, 700);
    repeat (4) push4(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024,
                     int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
    repeat (3) push4(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    n_per = stim_q.size() / NI;
    repeat (1 + n_per * PER) step();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
